// File: rtl/draw_cmd_sched.sv
// draw_cmd_sched: plays a drawing-command list and dispatches draw commands to the shape engine one at a time
module draw_cmd_sched #(
  parameter int CMDW     = 40,
  parameter int ADDRW    = 8,
  parameter int LIST_LEN = 256
) (
  input  logic             clk_sys,
  input  logic             rst_sys,
  input  logic             start,
  input  logic             frame,
  output logic [ADDRW-1:0] list_addr,
  input  logic [CMDW-1:0]  list_data,
  output logic [CMDW-1:0]  cmd_data,
  output logic             cmd_start,
  input  logic             eng_busy,
  input  logic             eng_done,
  output logic             busy,
  output logic             done,
  output logic [ADDRW-1:0] cmd_count,
  output logic             err
);
  typedef enum logic [2:0] {IDLE, READ, DECODE, DISPATCH, ENGINE, WAITF, NEXT, FIN} state_t;
  localparam logic [ADDRW-1:0] LAST = ADDRW'(LIST_LEN - 1);
  localparam logic [ADDRW-1:0] CMAX = '1;
  state_t state, state_nx;
  logic [7:0] fcnt;
  logic [3:0] op;
  assign op        = list_data[CMDW-1:CMDW-4];
  assign cmd_start = state == DISPATCH && !eng_busy && !rst_sys;
  assign busy      = state != IDLE;
  assign done      = state == FIN;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = start ? READ : IDLE;
      READ:     state_nx = DECODE;
      DECODE:   state_nx = op == 4'd1 ? DISPATCH : op == 4'd2 ? WAITF : op == 4'd0 ? FIN : NEXT;
      DISPATCH: state_nx = eng_busy ? DISPATCH : ENGINE;
      ENGINE:   state_nx = eng_done ? NEXT : ENGINE;
      WAITF:    state_nx = fcnt == 8'd0 ? NEXT : WAITF;
      NEXT:     state_nx = list_addr == LAST ? FIN : READ;
      FIN:      state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state     <= IDLE;
      list_addr <= '0;
      cmd_data  <= '0;
      cmd_count <= '0;
      err       <= 1'b0;
      fcnt      <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        list_addr <= '0;
        cmd_count <= '0;
        err       <= 1'b0;
      end
      if (state == DECODE && op == 4'd1) cmd_data <= list_data;
      if (state == DECODE && op == 4'd2) fcnt <= list_data[7:0] == 8'd0 ? 8'd1 : list_data[7:0];
      if (state == DECODE && op > 4'd3) err <= 1'b1;
      if (cmd_start && cmd_count != CMAX) cmd_count <= cmd_count + ADDRW'(1);
      if (state == WAITF && frame && fcnt != 8'd0) fcnt <= fcnt - 8'd1;
      if (state == NEXT && list_addr != LAST) list_addr <= list_addr + ADDRW'(1);
    end
  end
endmodule

// File: tb/tb_draw_cmd_sched.sv
// tb_draw_cmd_sched: directed bench with list memory, engine model and cycle-accurate expectations
module tb_draw_cmd_sched;
  localparam int CMDW = 40, ADDRW = 2, LIST_LEN = 4;
  localparam logic [CMDW-1:0] C_A = {4'h1, 36'hAAAAA0001};
  localparam logic [CMDW-1:0] C_B = {4'h1, 36'hBBBBB0002};
  localparam logic [CMDW-1:0] C_C = {4'h1, 36'hCCCCC0003};
  localparam logic [CMDW-1:0] C_D = {4'h1, 36'hDDDDD0004};
  localparam logic [CMDW-1:0] C_E = {4'h1, 36'hEEEEE0005};
  localparam logic [CMDW-1:0] C_F = {4'h1, 36'hFFFFF0006};
  localparam logic [CMDW-1:0] C_G = {4'h1, 36'h123450007};
  localparam logic [CMDW-1:0] C_BAD = {4'h9, 36'h000000009};
  localparam logic [CMDW-1:0] C_END = '0;
  logic clk_sys = 0, rst_sys = 1, start = 0, frame = 0, eng_done = 0, force_busy = 0;
  logic eng_busy, cmd_start, busy, done, err;
  logic [ADDRW-1:0] list_addr, cmd_count, done_addr, done_cnt;
  logic [CMDW-1:0] list_data, cmd_data, held;
  logic done_err, pend = 0, in_eng = 0;
  logic [CMDW-1:0] mem [LIST_LEN];
  int cyc = 0, t0 = 0, n_cmp = 0, n_bad = 0, eng_cnt = 0, ndone = 0, done_off = 0, stab_err = 0;
  int cs_off[$];
  logic [CMDW-1:0] cs_data[$];

  draw_cmd_sched #(.CMDW(CMDW), .ADDRW(ADDRW), .LIST_LEN(LIST_LEN)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .start(start), .frame(frame),
    .list_addr(list_addr), .list_data(list_data), .cmd_data(cmd_data), .cmd_start(cmd_start),
    .eng_busy(eng_busy), .eng_done(eng_done), .busy(busy), .done(done),
    .cmd_count(cmd_count), .err(err)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) list_data <= mem[list_addr];
  assign eng_busy = force_busy | (eng_cnt != 0);

  initial forever begin
    @(posedge clk_sys);
    cyc++;
  end

  // engine registers cmd_start, stays busy, and pulses eng_done 5 cycles after the start pulse
  initial forever begin
    @(posedge clk_sys);
    #1;
    eng_done = 0;
    if (pend) begin
      eng_cnt = 4;
      pend = 0;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) eng_done = 1;
    end
    @(negedge clk_sys);
    if (rst_sys) begin
      eng_cnt = 0;
      pend = 0;
    end else if (cmd_start) pend = 1;
  end

  initial forever begin
    @(negedge clk_sys);
    if (rst_sys) in_eng = 0;
    if (cmd_start) begin
      cs_off.push_back(cyc - t0);
      cs_data.push_back(cmd_data);
      held = cmd_data;
      in_eng = 1;
    end else if (in_eng && cmd_data !== held) stab_err++;
    if (eng_done) in_eng = 0;
    if (done) begin
      ndone++;
      done_off = cyc - t0;
      done_addr = list_addr;
      done_cnt = cmd_count;
      done_err = err;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic go();
    cs_off.delete();
    cs_data.delete();
    ndone = 0;
    stab_err = 0;
    start = 1;
    t0 = cyc;
    tick(1);
    start = 0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (ndone == 0 && n < budget) begin
      tick(1);
      n++;
    end
    tick(3);
    chk("n_done", 64'(ndone), 1);
  endtask

  function automatic int off_at(input int i);
    return i < cs_off.size() ? cs_off[i] : -1;
  endfunction

  function automatic logic [CMDW-1:0] data_at(input int i);
    return i < cs_data.size() ? cs_data[i] : '0;
  endfunction

  task automatic load(input logic [CMDW-1:0] w0, w1, w2, w3);
    mem[0] = w0;
    mem[1] = w1;
    mem[2] = w2;
    mem[3] = w3;
  endtask

  initial begin
    load(C_END, C_END, C_END, C_END);
    tick(2);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_addr", 64'(list_addr), 0);
    chk("rst_data", 64'(cmd_data), 0);
    chk("rst_cs", 64'(cmd_start), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_cnt", 64'(cmd_count), 0);
    chk("rst_err", 64'(err), 0);
    rst_sys = 0;
    tick(2);

    load(C_A, C_B, C_END, C_END);
    go();
    wait_done(60);
    chk("t1_off0", 64'(off_at(0)), 3);
    chk("t1_d0", 64'(data_at(0)), 64'(C_A));
    chk("t1_off1", 64'(off_at(1)), 12);
    chk("t1_d1", 64'(data_at(1)), 64'(C_B));
    chk("t1_n", 64'(cs_off.size()), 2);
    chk("t1_done_off", 64'(done_off), 21);
    chk("t1_cnt", 64'(done_cnt), 2);
    chk("t1_stab", 64'(stab_err), 0);
    chk("t1_busy", 64'(busy), 0);

    load(C_A, C_END, C_END, C_END);
    go();
    tick_to(t0 + 5);
    start = 1;
    tick(1);
    start = 0;
    wait_done(60);
    chk("t2_off0", 64'(off_at(0)), 3);
    chk("t2_done_off", 64'(done_off), 12);
    tick(20);
    chk("t2_n", 64'(cs_off.size()), 1);
    chk("t2_busy", 64'(busy), 0);

    load({4'h2, 28'h0, 8'd3}, C_C, C_END, C_END);
    go();
    tick_to(t0 + 2);
    frame = 1;
    tick(1);
    frame = 0;
    for (int k = 1; k <= 3; k++) begin
      tick_to(t0 + 100 * k);
      frame = 1;
      tick(1);
      frame = 0;
    end
    chk("t3_pre", 64'(cs_off.size()), 0);
    wait_done(100);
    chk("t3_off0", 64'(off_at(0)), 305);
    chk("t3_d0", 64'(data_at(0)), 64'(C_C));
    chk("t3_done_off", 64'(done_off), 314);

    load({4'h2, 28'h0, 8'd0}, C_C, C_END, C_END);
    go();
    tick_to(t0 + 50);
    chk("t3z_pre", 64'(cs_off.size()), 0);
    frame = 1;
    tick(1);
    frame = 0;
    wait_done(100);
    chk("t3z_off0", 64'(off_at(0)), 55);
    chk("t3z_done_off", 64'(done_off), 64);

    load(C_D, C_END, C_END, C_END);
    force_busy = 1;
    go();
    tick_to(t0 + 23);
    chk("t4_pre", 64'(cs_off.size()), 0);
    force_busy = 0;
    wait_done(60);
    chk("t4_off0", 64'(off_at(0)), 23);
    chk("t4_n", 64'(cs_off.size()), 1);
    chk("t4_stab", 64'(stab_err), 0);
    chk("t4_done_off", 64'(done_off), 32);
    chk("t4_keep", 64'(cmd_data), 64'(C_D));

    load(C_E, C_BAD, C_F, C_G);
    go();
    wait_done(80);
    chk("t5_off0", 64'(off_at(0)), 3);
    chk("t5_off1", 64'(off_at(1)), 15);
    chk("t5_off2", 64'(off_at(2)), 24);
    chk("t5_done_off", 64'(done_off), 31);
    chk("t5_addr", 64'(done_addr), 3);
    chk("t5_err", 64'(done_err), 1);
    chk("t5_cnt", 64'(done_cnt), 3);
    chk("t5_err_hold", 64'(err), 1);

    load(C_E, C_F, C_G, C_A);
    go();
    tick(1);
    chk("t5s_err_clr", 64'(err), 0);
    wait_done(80);
    chk("t5s_n", 64'(cs_off.size()), 4);
    chk("t5s_off3", 64'(off_at(3)), 30);
    chk("t5s_cnt", 64'(done_cnt), 3);
    chk("t5s_done_off", 64'(done_off), 37);

    load(C_A, C_B, C_END, C_END);
    go();
    tick_to(t0 + 3);
    rst_sys = 1;
    @(negedge clk_sys);
    chk("t6_cs_rst", 64'(cmd_start), 0);
    tick(1);
    rst_sys = 0;
    chk("t6a_busy", 64'(busy), 0);
    tick(2);
    chk("t6a_n", 64'(cs_off.size()), 0);

    go();
    tick_to(t0 + 5);
    rst_sys = 1;
    start = 1;
    tick(1);
    rst_sys = 0;
    start = 0;
    chk("t6_busy", 64'(busy), 0);
    chk("t6_addr", 64'(list_addr), 0);
    chk("t6_data", 64'(cmd_data), 0);
    chk("t6_cs", 64'(cmd_start), 0);
    chk("t6_done", 64'(done), 0);
    chk("t6_cnt", 64'(cmd_count), 0);
    chk("t6_err", 64'(err), 0);
    tick(3);
    go();
    wait_done(60);
    chk("t6r_off0", 64'(off_at(0)), 3);
    chk("t6r_d0", 64'(data_at(0)), 64'(C_A));
    chk("t6r_off1", 64'(off_at(1)), 12);
    chk("t6r_cnt", 64'(done_cnt), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
